// File: rtl/atm_session_ctrl_pkg.sv
// atm_session_ctrl_pkg: shared state, operation and error codes for the
// ATM session controller and its account bank.
package atm_session_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAITING = 3'd1,
    ST_AUTH    = 3'd2,
    ST_MENU    = 3'd3,
    ST_EXEC    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_BALANCE    = 3'd0,
    OP_WITHDRAW   = 3'd1,
    OP_DEPOSIT    = 3'd2,
    OP_CHANGE_PIN = 3'd3,
    OP_EXIT       = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_NO_ACC   = 3'd1,
    ERR_BAD_PIN  = 3'd2,
    ERR_LOCKED   = 3'd3,
    ERR_NO_FUNDS = 3'd4,
    ERR_LIMIT    = 3'd5,
    ERR_OVERFLOW = 3'd6,
    ERR_TIMEOUT  = 3'd7
  } err_t;

  // Operations that go through the one-cycle EXEC state (EXIT is handled in MENU).
  function automatic logic is_exec_op(input logic [2:0] op);
    return (op <= OP_CHANGE_PIN);
  endfunction

endpackage

// File: rtl/atm_session_ctrl_bank.sv
// atm_account_bank: per-account PIN, balance, PIN-retry counter and lock bit.
// One combinational read port by index, one registered write port.
module atm_account_bank
  import atm_session_ctrl_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10,
  parameter int BAL_W        = 32,
  parameter int PIN_W        = 16,
  parameter int TRY_W        = 2,
  parameter int ACC_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ACC_W-1:0] i_rd_idx,
  output logic [PIN_W-1:0] o_rd_pin,
  output logic [BAL_W-1:0] o_rd_bal,
  output logic [TRY_W-1:0] o_rd_tries,
  output logic             o_rd_lock,
  input  logic [ACC_W-1:0] i_wr_idx,
  input  logic             i_we_pin,
  input  logic [PIN_W-1:0] i_wr_pin,
  input  logic             i_we_bal,
  input  logic [BAL_W-1:0] i_wr_bal,
  input  logic             i_we_auth,
  input  logic [TRY_W-1:0] i_wr_tries,
  input  logic             i_wr_lock
);

  logic [PIN_W-1:0] r_pin   [NUM_ACCOUNTS];
  logic [BAL_W-1:0] r_bal   [NUM_ACCOUNTS];
  logic [TRY_W-1:0] r_tries [NUM_ACCOUNTS];
  logic             r_lock  [NUM_ACCOUNTS];

  logic w_rd_ok;
  logic w_wr_ok;

  assign w_rd_ok = (int'(i_rd_idx) < NUM_ACCOUNTS);
  assign w_wr_ok = (int'(i_wr_idx) < NUM_ACCOUNTS);

  // Read port: out-of-range indices return zeros instead of X.
  always_comb begin
    o_rd_pin   = '0;
    o_rd_bal   = '0;
    o_rd_tries = '0;
    o_rd_lock  = FALSE;
    if (w_rd_ok) begin
      o_rd_pin   = r_pin[i_rd_idx];
      o_rd_bal   = r_bal[i_rd_idx];
      o_rd_tries = r_tries[i_rd_idx];
      o_rd_lock  = r_lock[i_rd_idx];
    end
  end

  // Store update: reset reloads defaults, otherwise apply the enabled field writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_pin[i]   <= '0;
        r_bal[i]   <= BAL_W'(1000 * (i + 1));
        r_tries[i] <= '0;
        r_lock[i]  <= FALSE;
      end
    end else if (w_wr_ok) begin
      if (i_we_pin) r_pin[i_wr_idx] <= i_wr_pin;
      if (i_we_bal) r_bal[i_wr_idx] <= i_wr_bal;
      if (i_we_auth) begin
        r_tries[i_wr_idx] <= i_wr_tries;
        r_lock[i_wr_idx]  <= i_wr_lock;
      end
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN session FSM with registered results, an
// op_valid/done handshake, PIN lockout, menu idle timeout and a per-session
// withdraw limit. Account state lives in atm_account_bank.
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter  int NUM_ACCOUNTS  = 10,
  parameter  int BAL_W         = 32,
  parameter  int PIN_W         = 16,
  parameter  int MAX_PIN_TRIES = 3,
  parameter  int TIMEOUT_CYC   = 1000,
  parameter  int SESSION_LIMIT = 5000,
  localparam int ACC_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_card_valid,
  input  logic [ACC_W-1:0] i_acc_num,
  input  logic [PIN_W-1:0] i_pin,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op,
  input  logic [BAL_W-1:0] i_amount,
  input  logic [PIN_W-1:0] i_new_pin,
  output logic [BAL_W-1:0] o_balance,
  output logic             o_success,
  output logic             o_done,
  output logic [2:0]       o_err_code,
  output logic             o_busy,
  output logic [2:0]       o_state
);

  localparam int TRY_W = (MAX_PIN_TRIES > 1) ? $clog2(MAX_PIN_TRIES + 1) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TRY_W-1:0] TRY_MAX     = TRY_W'(MAX_PIN_TRIES);
  localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [BAL_W:0]   LIMIT_EXT   = (BAL_W + 1)'(SESSION_LIMIT);
  localparam logic [ACC_W:0]   NUM_ACC_EXT = (ACC_W + 1)'(NUM_ACCOUNTS);

  state_t           r_state,   w_state_nx;
  logic [ACC_W-1:0] r_acc,     w_acc_nx;
  logic [PIN_W-1:0] r_pin_in,  w_pin_in_nx;
  logic [2:0]       r_op,      w_op_nx;
  logic [BAL_W-1:0] r_amount,  w_amount_nx;
  logic [PIN_W-1:0] r_new_pin, w_new_pin_nx;
  logic [TMR_W-1:0] r_timer,   w_timer_nx;
  logic [BAL_W-1:0] r_sess,    w_sess_nx;
  logic [BAL_W-1:0] r_balance, w_balance_nx;
  logic             r_success, w_success_nx;
  logic             r_done,    w_done_nx;
  err_t             r_err,     w_err_nx;
  logic             r_busy,    w_busy_nx;

  logic [ACC_W-1:0] w_rd_idx;
  logic [PIN_W-1:0] w_rd_pin;
  logic [BAL_W-1:0] w_rd_bal;
  logic [TRY_W-1:0] w_rd_tries;
  logic             w_rd_lock;
  logic             w_we_pin;
  logic             w_we_bal;
  logic [BAL_W-1:0] w_wr_bal;
  logic             w_we_auth;
  logic [TRY_W-1:0] w_wr_tries;
  logic             w_wr_lock;
  logic [TRY_W-1:0] w_tries_inc;
  logic [BAL_W:0]   w_dep_sum;
  logic [BAL_W:0]   w_sess_sum;

  // WAITING looks up the card being offered; later states use the latched account.
  assign w_rd_idx    = (r_state == ST_WAITING) ? i_acc_num : r_acc;
  assign w_tries_inc = w_rd_tries + TRY_W'(1);
  assign w_dep_sum   = {1'b0, w_rd_bal} + {1'b0, r_amount};
  assign w_sess_sum  = {1'b0, r_sess} + {1'b0, r_amount};

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS),
    .BAL_W       (BAL_W),
    .PIN_W       (PIN_W),
    .TRY_W       (TRY_W),
    .ACC_W       (ACC_W)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rd_idx  (w_rd_idx),
    .o_rd_pin  (w_rd_pin),
    .o_rd_bal  (w_rd_bal),
    .o_rd_tries(w_rd_tries),
    .o_rd_lock (w_rd_lock),
    .i_wr_idx  (r_acc),
    .i_we_pin  (w_we_pin),
    .i_wr_pin  (r_new_pin),
    .i_we_bal  (w_we_bal),
    .i_wr_bal  (w_wr_bal),
    .i_we_auth (w_we_auth),
    .i_wr_tries(w_wr_tries),
    .i_wr_lock (w_wr_lock)
  );

  // Next-state, result and store-write decode. While done is high, new
  // card/op requests are held off one cycle so done can never pulse twice in a row.
  always_comb begin
    w_state_nx   = r_state;
    w_acc_nx     = r_acc;
    w_pin_in_nx  = r_pin_in;
    w_op_nx      = r_op;
    w_amount_nx  = r_amount;
    w_new_pin_nx = r_new_pin;
    w_timer_nx   = r_timer;
    w_sess_nx    = r_sess;
    w_balance_nx = r_balance;
    w_success_nx = r_success;
    w_done_nx    = FALSE;
    w_err_nx     = r_err;
    w_we_pin     = FALSE;
    w_we_bal     = FALSE;
    w_wr_bal     = w_rd_bal;
    w_we_auth    = FALSE;
    w_wr_tries   = '0;
    w_wr_lock    = FALSE;

    case (r_state)
      ST_IDLE: w_state_nx = ST_WAITING;

      ST_WAITING: begin
        if (i_card_valid && !r_done) begin
          if ({1'b0, i_acc_num} >= NUM_ACC_EXT) begin
            w_err_nx     = ERR_NO_ACC;
            w_success_nx = FALSE;
            w_done_nx    = TRUE;
          end else if (w_rd_lock) begin
            w_err_nx     = ERR_LOCKED;
            w_success_nx = FALSE;
            w_done_nx    = TRUE;
          end else begin
            w_acc_nx    = i_acc_num;
            w_pin_in_nx = i_pin;
            w_state_nx  = ST_AUTH;
          end
        end
      end

      ST_AUTH: begin
        w_we_auth = TRUE;
        w_done_nx = TRUE;
        if (r_pin_in == w_rd_pin) begin
          w_wr_tries   = '0;
          w_success_nx = TRUE;
          w_err_nx     = ERR_NONE;
          w_sess_nx    = '0;
          w_timer_nx   = '0;
          w_state_nx   = ST_MENU;
        end else begin
          w_wr_tries   = w_tries_inc;
          w_success_nx = FALSE;
          w_state_nx   = ST_WAITING;
          if (w_tries_inc >= TRY_MAX) begin
            w_wr_lock = TRUE;
            w_err_nx  = ERR_LOCKED;
          end else begin
            w_err_nx  = ERR_BAD_PIN;
          end
        end
      end

      ST_MENU: begin
        if (i_op_valid && !r_done) begin
          w_timer_nx = '0;
          if (i_op == OP_EXIT) begin
            w_success_nx = TRUE;
            w_err_nx     = ERR_NONE;
            w_done_nx    = TRUE;
            w_state_nx   = ST_WAITING;
          end else if (is_exec_op(i_op)) begin
            w_op_nx      = i_op;
            w_amount_nx  = i_amount;
            w_new_pin_nx = i_new_pin;
            w_state_nx   = ST_EXEC;
          end else begin
            w_success_nx = FALSE;
            w_err_nx     = ERR_NONE;
            w_done_nx    = TRUE;
          end
        end else if (r_timer == TMR_LAST) begin
          w_timer_nx   = '0;
          w_success_nx = FALSE;
          w_err_nx     = ERR_TIMEOUT;
          w_done_nx    = TRUE;
          w_state_nx   = ST_WAITING;
        end else begin
          w_timer_nx = r_timer + TMR_W'(1);
        end
      end

      ST_EXEC: begin
        w_state_nx   = ST_MENU;
        w_timer_nx   = '0;
        w_done_nx    = TRUE;
        w_balance_nx = w_rd_bal;
        w_success_nx = FALSE;
        w_err_nx     = ERR_NONE;
        case (r_op)
          OP_WITHDRAW: begin
            // Limit is reported ahead of insufficient funds when both apply.
            if (r_amount == '0) begin
              w_err_nx = ERR_NO_FUNDS;
            end else if (w_sess_sum > LIMIT_EXT) begin
              w_err_nx = ERR_LIMIT;
            end else if (r_amount > w_rd_bal) begin
              w_err_nx = ERR_NO_FUNDS;
            end else begin
              w_we_bal     = TRUE;
              w_wr_bal     = w_rd_bal - r_amount;
              w_balance_nx = w_rd_bal - r_amount;
              w_sess_nx    = w_sess_sum[BAL_W-1:0];
              w_success_nx = TRUE;
            end
          end
          OP_DEPOSIT: begin
            if (w_dep_sum[BAL_W]) begin
              w_err_nx = ERR_OVERFLOW;
            end else begin
              w_we_bal     = (r_amount != '0);
              w_wr_bal     = w_dep_sum[BAL_W-1:0];
              w_balance_nx = w_dep_sum[BAL_W-1:0];
              w_success_nx = TRUE;
            end
          end
          OP_CHANGE_PIN: begin
            w_we_pin     = TRUE;
            w_success_nx = TRUE;
          end
          default: w_success_nx = TRUE;
        endcase
      end

      default: w_state_nx = ST_IDLE;
    endcase

    w_busy_nx = (w_state_nx != ST_WAITING) && (w_state_nx != ST_MENU);
  end

  // Session, FSM and output registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_pin_in  <= '0;
      r_op      <= '0;
      r_amount  <= '0;
      r_new_pin <= '0;
      r_timer   <= '0;
      r_sess    <= '0;
      r_balance <= '0;
      r_success <= FALSE;
      r_done    <= FALSE;
      r_err     <= ERR_NONE;
      r_busy    <= FALSE;
    end else begin
      r_state   <= w_state_nx;
      r_acc     <= w_acc_nx;
      r_pin_in  <= w_pin_in_nx;
      r_op      <= w_op_nx;
      r_amount  <= w_amount_nx;
      r_new_pin <= w_new_pin_nx;
      r_timer   <= w_timer_nx;
      r_sess    <= w_sess_nx;
      r_balance <= w_balance_nx;
      r_success <= w_success_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_busy    <= w_busy_nx;
    end
  end

  assign o_balance  = r_balance;
  assign o_success  = r_success;
  assign o_done     = r_done;
  assign o_err_code = r_err;
  assign o_busy     = r_busy;
  assign o_state    = r_state;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed scenarios for the ATM session controller
// with hand-computed expected results.
module tb_atm_session_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_MENU = 3'd3, S_EXEC = 3'd4;
  localparam logic [2:0] O_BAL = 3'd0, O_WD = 3'd1, O_DEP = 3'd2, O_CHG = 3'd3, O_EXIT = 3'd4;
  localparam logic [2:0] E_NONE = 3'd0, E_NO_ACC = 3'd1, E_BAD_PIN = 3'd2, E_LOCKED = 3'd3;
  localparam logic [2:0] E_NO_FUNDS = 3'd4, E_LIMIT = 3'd5, E_OVERFLOW = 3'd6, E_TIMEOUT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_valid;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] amount;
  logic [15:0] new_pin;
  logic [31:0] balance;
  logic        success;
  logic        done;
  logic [2:0]  err_code;
  logic        busy;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  atm_session_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_card_valid(card_valid),
    .i_acc_num   (acc_num),
    .i_pin       (pin),
    .i_op_valid  (op_valid),
    .i_op        (op),
    .i_amount    (amount),
    .i_new_pin   (new_pin),
    .o_balance   (balance),
    .o_success   (success),
    .o_done      (done),
    .o_err_code  (err_code),
    .o_busy      (busy),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  // Offer a card for one cycle, then wait (bounded) for the done pulse.
  task automatic do_card(input logic [3:0] acc, input logic [15:0] p, output bit got);
    got = 1'b0;
    @(negedge clk);
    card_valid = 1'b1; acc_num = acc; pin = p;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      card_valid = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  // Request one operation for one cycle, then wait (bounded) for the done pulse.
  task automatic do_op(input logic [2:0] o, input logic [31:0] amt, input logic [15:0] np, output bit got);
    got = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; op = o; amount = amt; new_pin = np;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; card_valid = 1'b0; acc_num = '0; pin = '0;
    op_valid = 1'b0; op = '0; amount = '0; new_pin = '0;
    repeat (3) @(negedge clk);
    checks++; if (state !== S_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
    checks++; if ({done, success, busy, err_code} !== 6'd0) begin errors++; $display("[TB] FAIL reset_flags got done=%0b succ=%0b busy=%0b err=%0d exp all 0", done, success, busy, err_code); end
    checks++; if (balance !== 32'd0) begin errors++; $display("[TB] FAIL reset_balance got=%0d exp=0", balance); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (state !== S_WAIT) begin errors++; $display("[TB] FAIL idle_to_wait got=%0d exp=%0d", state, S_WAIT); end
  endtask

  task automatic test_login_balance;
    bit got;
    do_card(4'd2, 16'd0, got);
    checks++; if (!got) begin errors++; $display("[TB] FAIL login2_done got=0 exp=1"); end
    checks++; if ({success, err_code, state} !== {1'b1, E_NONE, S_MENU}) begin errors++; $display("[TB] FAIL login2_result got succ=%0b err=%0d st=%0d exp 1/0/3", success, err_code, state); end
    @(negedge clk);
    op_valid = 1'b1; op = O_BAL;
    @(negedge clk);
    op_valid = 1'b0;
    checks++; if ({state, busy} !== {S_EXEC, 1'b1}) begin errors++; $display("[TB] FAIL exec_busy got st=%0d busy=%0b exp 4/1", state, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL balance_latency got done=%0b exp=1", done); end
    checks++; if (balance !== 32'd3000) begin errors++; $display("[TB] FAIL balance_acc2 got=%0d exp=3000", balance); end
    checks++; if ({success, state, busy} !== {1'b1, S_MENU, 1'b0}) begin errors++; $display("[TB] FAIL balance_flags got succ=%0b st=%0d busy=%0b exp 1/3/0", success, state, busy); end
  endtask

  task automatic test_withdraw;
    bit got;
    do_op(O_WD, 32'd1200, 16'd0, got);
    checks++; if (!got || success !== 1'b1 || balance !== 32'd1800) begin errors++; $display("[TB] FAIL wd1200 got done=%0b succ=%0b bal=%0d exp 1/1/1800", got, success, balance); end
    do_op(O_WD, 32'd4000, 16'd0, got);
    checks++; if (!got || success !== 1'b0) begin errors++; $display("[TB] FAIL wd4000_succ got done=%0b succ=%0b exp 1/0", got, success); end
    checks++; if (err_code !== E_LIMIT) begin errors++; $display("[TB] FAIL wd4000_err got=%0d exp=%0d", err_code, E_LIMIT); end
    checks++; if (balance !== 32'd1800) begin errors++; $display("[TB] FAIL wd4000_bal got=%0d exp=1800", balance); end
    do_op(O_EXIT, 32'd0, 16'd0, got);
    checks++; if (!got || {success, state} !== {1'b1, S_WAIT}) begin errors++; $display("[TB] FAIL exit got done=%0b succ=%0b st=%0d exp 1/1/1", got, success, state); end
  endtask

  task automatic test_lockout;
    bit got;
    logic [2:0] exp_err [3] = '{E_BAD_PIN, E_BAD_PIN, E_LOCKED};
    for (int i = 0; i < 3; i++) begin
      do_card(4'd5, 16'd7, got);
      checks++; if (!got || err_code !== exp_err[i] || success !== 1'b0 || state !== S_WAIT) begin errors++; $display("[TB] FAIL wrong_pin_%0d got done=%0b err=%0d succ=%0b st=%0d exp err=%0d", i, got, err_code, success, state, exp_err[i]); end
    end
    do_card(4'd5, 16'd0, got);
    checks++; if (!got || err_code !== E_LOCKED || success !== 1'b0) begin errors++; $display("[TB] FAIL locked_right_pin got done=%0b err=%0d succ=%0b exp 1/3/0", got, err_code, success); end
  endtask

  task automatic test_no_acc;
    bit got;
    do_card(4'd12, 16'd0, got);
    checks++; if (!got || err_code !== E_NO_ACC || state !== S_WAIT) begin errors++; $display("[TB] FAIL no_acc got done=%0b err=%0d st=%0d exp 1/1/1", got, err_code, state); end
  endtask

  task automatic test_deposit_funds;
    bit got;
    do_card(4'd0, 16'd0, got);
    checks++; if (!got || success !== 1'b1) begin errors++; $display("[TB] FAIL login0 got done=%0b succ=%0b exp 1/1", got, success); end
    do_op(O_DEP, 32'hFFFF_FFFF, 16'd0, got);
    checks++; if (!got || err_code !== E_OVERFLOW || success !== 1'b0 || balance !== 32'd1000) begin errors++; $display("[TB] FAIL dep_overflow got err=%0d succ=%0b bal=%0d exp 6/0/1000", err_code, success, balance); end
    do_op(O_WD, 32'd1500, 16'd0, got);
    checks++; if (!got || err_code !== E_NO_FUNDS || balance !== 32'd1000) begin errors++; $display("[TB] FAIL wd_no_funds got err=%0d bal=%0d exp 4/1000", err_code, balance); end
    do_op(O_WD, 32'd0, 16'd0, got);
    checks++; if (!got || err_code !== E_NO_FUNDS || success !== 1'b0) begin errors++; $display("[TB] FAIL wd_zero got err=%0d succ=%0b exp 4/0", err_code, success); end
    do_op(O_DEP, 32'd500, 16'd0, got);
    checks++; if (!got || success !== 1'b1 || balance !== 32'd1500) begin errors++; $display("[TB] FAIL dep500 got succ=%0b bal=%0d exp 1/1500", success, balance); end
    do_op(3'd6, 32'd0, 16'd0, got);
    checks++; if (!got || {success, err_code, state} !== {1'b0, E_NONE, S_MENU}) begin errors++; $display("[TB] FAIL bad_op got done=%0b succ=%0b err=%0d st=%0d exp 1/0/0/3", got, success, err_code, state); end
  endtask

  task automatic test_change_pin;
    bit got;
    do_op(O_CHG, 32'd0, 16'd1234, got);
    checks++; if (!got || success !== 1'b1) begin errors++; $display("[TB] FAIL chg_pin got done=%0b succ=%0b exp 1/1", got, success); end
    do_op(O_EXIT, 32'd0, 16'd0, got);
    do_card(4'd0, 16'd0, got);
    checks++; if (!got || err_code !== E_BAD_PIN) begin errors++; $display("[TB] FAIL old_pin got done=%0b err=%0d exp 1/2", got, err_code); end
    do_card(4'd0, 16'd1234, got);
    checks++; if (!got || success !== 1'b1 || state !== S_MENU) begin errors++; $display("[TB] FAIL new_pin got done=%0b succ=%0b st=%0d exp 1/1/3", got, success, state); end
    do_op(O_BAL, 32'd0, 16'd0, got);
    checks++; if (!got || balance !== 32'd1500) begin errors++; $display("[TB] FAIL acc0_bal got=%0d exp=1500", balance); end
  endtask

  task automatic test_limit_boundary;
    bit got;
    do_op(O_EXIT, 32'd0, 16'd0, got);
    do_card(4'd9, 16'd0, got);
    do_op(O_WD, 32'd5000, 16'd0, got);
    checks++; if (!got || success !== 1'b1 || balance !== 32'd5000) begin errors++; $display("[TB] FAIL wd_at_limit got succ=%0b bal=%0d exp 1/5000", success, balance); end
    do_op(O_WD, 32'd1, 16'd0, got);
    checks++; if (!got || err_code !== E_LIMIT || balance !== 32'd5000) begin errors++; $display("[TB] FAIL wd_over_limit got err=%0d bal=%0d exp 5/5000", err_code, balance); end
    do_op(O_EXIT, 32'd0, 16'd0, got);
    do_card(4'd9, 16'd0, got);
    do_op(O_WD, 32'd1, 16'd0, got);
    checks++; if (!got || success !== 1'b1 || balance !== 32'd4999) begin errors++; $display("[TB] FAIL new_session_wd got succ=%0b bal=%0d exp 1/4999", success, balance); end
  endtask

  task automatic test_timeout;
    bit got = 1'b0;
    int cnt = 0;
    while (!got && cnt < 1100) begin
      @(negedge clk);
      cnt++;
      if (done) got = 1'b1;
    end
    checks++; if (!got || cnt != 1000) begin errors++; $display("[TB] FAIL timeout_cycles got done=%0b cycles=%0d exp 1/1000", got, cnt); end
    checks++; if ({err_code, state, success} !== {E_TIMEOUT, S_WAIT, 1'b0}) begin errors++; $display("[TB] FAIL timeout_result got err=%0d st=%0d succ=%0b exp 7/1/0", err_code, state, success); end
  endtask

  task automatic test_back_to_back;
    bit got;
    bit prev = 1'b0;
    int dcount = 0;
    int consec = 0;
    int bad_state = 0;
    do_card(4'd1, 16'd0, got);
    @(negedge clk);
    op_valid = 1'b1; op = 3'd7; card_valid = 1'b1; acc_num = 4'd3; pin = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (done && prev) consec++;
      if (state !== S_MENU) bad_state++;
      prev = done;
    end
    op_valid = 1'b0; card_valid = 1'b0;
    checks++; if (dcount != 5 || consec != 0) begin errors++; $display("[TB] FAIL held_op_done got pulses=%0d consecutive=%0d exp 5/0", dcount, consec); end
    checks++; if (bad_state != 0) begin errors++; $display("[TB] FAIL card_ignored_in_menu got off_menu_cycles=%0d exp=0", bad_state); end
    do_op(O_EXIT, 32'd0, 16'd0, got);
    checks++; if (!got || state !== S_WAIT) begin errors++; $display("[TB] FAIL b2b_exit got done=%0b st=%0d exp 1/1", got, state); end
  endtask

  task automatic test_reset_mid_exec;
    bit got;
    do_card(4'd3, 16'd0, got);
    @(negedge clk);
    op_valid = 1'b1; op = O_WD; amount = 32'd100;
    @(negedge clk);
    op_valid = 1'b0;
    checks++; if (state !== S_EXEC) begin errors++; $display("[TB] FAIL pre_reset_exec got st=%0d exp=4", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({state, done, busy} !== {S_IDLE, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL async_reset got st=%0d done=%0b busy=%0b exp 0/0/0", state, done, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_card(4'd3, 16'd0, got);
    do_op(O_BAL, 32'd0, 16'd0, got);
    checks++; if (!got || balance !== 32'd4000) begin errors++; $display("[TB] FAIL acc3_no_write got=%0d exp=4000", balance); end
    do_op(O_EXIT, 32'd0, 16'd0, got);
    do_card(4'd5, 16'd0, got);
    checks++; if (!got || success !== 1'b1 || state !== S_MENU) begin errors++; $display("[TB] FAIL lock_cleared got succ=%0b err=%0d st=%0d exp 1/0/3", success, err_code, state); end
  endtask

  initial begin
    test_reset();
    test_login_balance();
    test_withdraw();
    test_lockout();
    test_no_acc();
    test_deposit_funds();
    test_change_pin();
    test_limit_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
